dcache_mem_responder: RTL and testbench

- Memory-side responder for the core's dcache load/store ports. It replaces the always-ready fake SRAM hookup in the system block.
- Accepts load requests into an in-order queue and accepts stores.
- Arbitrates a single-port 64-bit backing memory between loads and stores.
- Returns load data in order after a fixed, parameterised latency. This models real port contention, so the core's handshakes get exercised.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/dcache_mem_responder.sv | 129 ++++++++++++
 tb/tb_dcache_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the dcache memory responder.
//   arb_state_e : which side won the single memory port most recently.
//   word_idx_t  : 64-bit word index into the backing memory (default width).
package dmem_pkg;

  localparam int unsigned WORD_IDX_W = 20;

  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  typedef enum logic {
    LAST_LOAD  = 1'b0,
    LAST_STORE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
//   clk, rst     : clock, synchronous active-high reset (pointers/count only)
//   push_i       : write push_data_i when not full
//   push_data_i  : entry to enqueue
//   pop_i        : drop the head entry when not empty
//   pop_data_o   : current head entry (valid when !empty_o)
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   count_o      : number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rptr_q];
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache load/store ports.
// Loads are queued in order, stores are written directly, and both share a
// single-port 64-bit memory. Under contention the port alternates between
// the two sides. Load data returns LOAD_LATENCY cycles after its read grant.
//   clk, rst      : clock, synchronous active-high reset
//   load_a_*      : load request (valid/ready/byte address)
//   load_d_*      : load response pulse and data (no back-pressure)
//   wvalid/wready : store handshake; waddr byte address, wdata full word
module dcache_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned ADDR_WIDTH   = WORD_IDX_W,
  parameter int unsigned LOAD_LATENCY = 2,
  parameter int unsigned LQ_DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_a_valid,
  output logic            load_a_ready,
  input  logic [XLEN-1:0] load_a_addr,
  output logic            load_d_valid,
  output logic [XLEN-1:0] load_d_data,
  input  logic            wvalid,
  output logic            wready,
  input  logic [XLEN-1:0] waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;
  localparam logic [CW-1:0] LQ_CNT_MAX = LQ_DEPTH[CW-1:0];

  typedef logic [ADDR_WIDTH-1:0] idx_t;

  logic [XLEN-1:0] mem_q [2**ADDR_WIDTH];

  idx_t            load_idx, store_idx, lq_head;
  logic [CW-1:0]   lq_count;
  logic            lq_empty, lq_full_unused;
  logic            lq_push;
  logic            grant_load, grant_store;
  arb_state_e      arb_q;

  // Byte offset and upper address bits are dropped, so high addresses alias.
  assign load_idx  = load_a_addr[ADDR_WIDTH+2:3];
  assign store_idx = waddr[ADDR_WIDTH+2:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{load_a_addr[2:0], load_a_addr[XLEN-1:ADDR_WIDTH+3],
                              waddr[2:0], waddr[XLEN-1:ADDR_WIDTH+3]};

  assign load_a_ready = !rst && (lq_count < LQ_CNT_MAX);
  assign lq_push      = load_a_valid && load_a_ready;

  // The queue count is registered, so a load accepted this cycle is not
  // visible to the arbiter until the next one.
  sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lq_push),
    .push_data_i (load_idx),
    .pop_i       (grant_load),
    .pop_data_o  (lq_head),
    .full_o      (lq_full_unused),
    .empty_o     (lq_empty),
    .count_o     (lq_count)
  );

  // Single-port arbitration: alternate when both sides want the port.
  always_comb begin
    grant_store = 1'b0;
    grant_load  = 1'b0;
    if (!rst) begin
      if (wvalid && !lq_empty) begin
        grant_store = (arb_q == LAST_LOAD);
        grant_load  = (arb_q == LAST_STORE);
      end else begin
        grant_store = wvalid;
        grant_load  = !lq_empty;
      end
    end
  end

  assign wready = grant_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q <= LAST_LOAD;
    end else if (grant_store) begin
      arb_q <= LAST_STORE;
    end else if (grant_load) begin
      arb_q <= LAST_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_store) mem_q[store_idx] <= wdata;
  end

  // Stage 0 is the synchronous memory read; stages 1..LOAD_LATENCY-1 delay it.
  // Data registers only advance with a valid beat so the output holds its
  // last value between responses.
  logic            vld_p  [LOAD_LATENCY];
  logic [XLEN-1:0] data_p [LOAD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= grant_load;
      if (grant_load) data_p[0] <= mem_q[lq_head];
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after it.
  assign load_d_valid = !rst && vld_p[LOAD_LATENCY-1];
  assign load_d_data  = rst ? '0 : data_p[LOAD_LATENCY-1];

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;

  localparam int AW = 20;
  localparam int LL = 2;
  localparam int LQD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_a_valid;
  logic        load_a_ready;
  logic [63:0] load_a_addr;
  logic        load_d_valid;
  logic [63:0] load_d_data;
  logic        wvalid;
  logic        wready;
  logic [63:0] waddr;
  logic [63:0] wdata;

  dcache_mem_responder #(
    .XLEN(64), .ADDR_WIDTH(AW), .LOAD_LATENCY(LL), .LQ_DEPTH(LQD)
  ) dut (
    .clk(clk), .rst(rst),
    .load_a_valid(load_a_valid), .load_a_ready(load_a_ready), .load_a_addr(load_a_addr),
    .load_d_valid(load_d_valid), .load_d_data(load_d_data),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    logic [63:0] data;
    int          exp_cyc;
  } sb_t;
  sb_t sb[$];

  logic [63:0] model [logic [AW-1:0]];

  function automatic logic [AW-1:0] widx(input logic [63:0] a);
    logic [63:0] t;
    t = a >> 3;
    return t[AW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Handshake observer: applies stores to the model first so a same-cycle
  // store is visible to a load accepted in that cycle, then queues expectations.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (wvalid && wready) model[widx(waddr)] = wdata;
      if (load_a_valid && load_a_ready) begin
        sb_t e;
        e.data    = model.exists(widx(load_a_addr)) ? model[widx(load_a_addr)] : 64'h0;
        e.exp_cyc = lat_chk ? cyc + 1 + LL : -1;
        sb.push_back(e);
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (load_d_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_resp: got data %h with nothing outstanding (cycle %0d)", load_d_data, cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("resp_data", load_d_data, e.data);
        if (e.exp_cyc >= 0) chk("resp_latency", 64'(cyc), 64'(e.exp_cyc));
      end
    end
  end

  task automatic send_load(input logic [63:0] a, output int stalls);
    bit got;
    stalls = 0;
    got = 1'b0;
    load_a_valid = 1'b1;
    load_a_addr  = a;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      got = load_a_ready;
      @(posedge clk);
      #1;
      if (got) break;
      stalls++;
    end
    load_a_valid = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL load_hs_timeout: addr %h never accepted", a);
    end
  endtask

  task automatic send_store(input logic [63:0] a, input logic [63:0] d, output int hs_cyc);
    bit got;
    got = 1'b0;
    hs_cyc = -1;
    wvalid = 1'b1;
    waddr  = a;
    wdata  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      got = wready;
      if (got) hs_cyc = cyc;
      @(posedge clk);
      #1;
      if (got) break;
    end
    wvalid = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL store_hs_timeout: addr %h never accepted", a);
    end
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    chk("drain_outstanding", 64'(sb.size()), 64'd0);
    if (!empty) sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st, hc, stall_sum, quiet;
    rst = 1'b1;
    load_a_valid = 1'b1;
    load_a_addr  = 64'h0;
    wvalid = 1'b1;
    waddr  = 64'h0;
    wdata  = 64'h0;

    // Reset state, with requests asserted to confirm ready is gated.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_load_a_ready", 64'(load_a_ready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_load_d_valid", 64'(load_d_valid), 64'd0);
    chk("rst_load_d_data", load_d_data, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_a_valid = 1'b0;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Store then load next cycle; 0x104 hits the same word.
    lat_chk = 1'b1;
    send_store(64'h100, 64'hDEADBEEF_CAFEF00D, hc);
    send_load(64'h100, st);
    send_load(64'h104, st);
    drain();

    // Populate 16 words, then 8 back-to-back loads with no stores.
    lat_chk = 1'b0;
    for (int i = 0; i < 16; i++)
      send_store(64'h200 + 64'(8 * i), {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)}, hc);
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_load(64'h200 + 64'(8 * i), st);
      chk("b2b_ready_stall", 64'(st), 64'd0);
    end
    drain();

    // Contention: 4 loads and 4 stores issued together. The first store targets
    // the first load's word in the same cycle, so that load sees the new data.
    lat_chk = 1'b0;
    fork
      begin
        int s;
        for (int i = 8; i < 12; i++) send_load(64'h200 + 64'(8 * i), s);
      end
      begin
        int c0, c1;
        send_store(64'h240, 64'h5555_6666_7777_8888, c0);
        for (int j = 1; j < 4; j++) begin
          send_store(64'h400 + 64'(8 * j), 64'h1000 + 64'(j), c1);
          chk("store_alt_gap", 64'(c1 - c0), 64'd2);
          c0 = c1;
        end
      end
    join
    drain();

    // Loads arrive faster than the half-rate drain, so the queue fills.
    stall_sum = 0;
    fork
      begin
        int s;
        for (int i = 0; i < 10; i++) begin
          send_load(64'h200 + 64'(8 * i), s);
          stall_sum += s;
        end
      end
      begin
        int c;
        for (int j = 0; j < 10; j++) send_store(64'h600 + 64'(8 * j), 64'h2000 + 64'(j), c);
      end
    join
    chk("lq_full_stall_seen", 64'(stall_sum != 0), 64'd1);
    drain();

    // Reset with loads queued and one in flight; nothing may emerge afterwards.
    wvalid = 1'b1;
    waddr  = 64'h800;
    wdata  = 64'h7777_0000_0000_0001;
    for (int i = 10; i < 16; i++) send_load(64'h200 + 64'(8 * i), st);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_load_a_ready", 64'(load_a_ready), 64'd0);
    chk("midrst_wready", 64'(wready), 64'd0);
    chk("midrst_load_d_valid", 64'(load_d_valid), 64'd0);
    chk("midrst_load_d_data", load_d_data, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wvalid = 1'b0;
    quiet = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (load_d_valid) quiet++;
    end
    chk("post_rst_valid_count", 64'(quiet), 64'd0);
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send_load(64'h250, st);
    drain();

    // Address alias: bit ADDR_WIDTH+3 and above are ignored.
    send_store(64'h8, 64'h0123_4567_89AB_CDEF, hc);
    send_load(64'h8 + (64'd1 << (AW + 3)), st);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
